// File: rtl/reg_dump_reader.sv
// reg_dump_reader: sequentially reads registers 0..NUM_REGS-1 and streams them out over valid/ready
//   clk, rst        system clock; asynchronous active-high reset
//   start           begin one dump pass (accepted in IDLE only)
//   rd_en/rd_addr   register-file read strobe and address
//   rd_data         register-file read data, valid READ_LAT cycles after rd_en
//   out_valid/out_ready/out_addr/out_data  word stream to the debug/display path
//   busy            pass in progress
//   done            one-cycle pulse after the last word is accepted
//   checksum        XOR of all words of the pass (only with REG_DUMP_CHECKSUM_EN defined)
module reg_dump_reader #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
`ifdef REG_DUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PRESENT, DONE} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] index;
    logic [2:0] lat_cnt;
    logic capture, last, accept;
    assign last      = index == ADDR_W'(NUM_REGS - 1);
    assign accept    = state == IDLE && start;
    // data lands at the end of ISSUE for a combinational file, else at the end of the last WAIT cycle
    assign capture   = (state == ISSUE && READ_LAT == 0) || (state == WAIT && lat_cnt == 3'd0);
    assign rd_en     = state == ISSUE;
    assign rd_addr   = index;
    assign out_valid = state == PRESENT;
    assign out_addr  = index;
    assign busy      = state inside {ISSUE, WAIT, PRESENT};
    assign done      = state == DONE;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ISSUE : IDLE;
            ISSUE:   state_nx = READ_LAT == 0 ? PRESENT : WAIT;
            WAIT:    state_nx = lat_cnt == 3'd0 ? PRESENT : WAIT;
            PRESENT: state_nx = out_ready ? (last ? DONE : ISSUE) : PRESENT;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            index    <= '0;
            lat_cnt  <= '0;
            out_data <= '0;
        end else begin
            state <= state_nx;
            if (accept)
                index <= '0;
            else if (state == PRESENT && out_ready && !last)
                index <= index + 1'b1;
            // counts down READ_LAT-1..0 over the WAIT cycles; value loaded is unused when READ_LAT=0
            if (state == ISSUE)
                lat_cnt <= 3'(READ_LAT - 1);
            else if (state == WAIT)
                lat_cnt <= lat_cnt - 1'b1;
            if (capture)
                out_data <= rd_data;
        end
    end
`ifdef REG_DUMP_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            checksum <= '0;
        else if (accept)
            checksum <= '0;
        else if (capture)
            checksum <= checksum ^ rd_data;
    end
`endif
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: self-checking bench for reg_dump_reader (default, READ_LAT=0 and READ_LAT=3 builds)
module tb_reg_dump_reader;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [DW-1:0] JUNK = 32'hDEAD_BEEF;

    logic clk = 0, rst = 0, start = 0, out_ready = 1, s_start = 0;
    always #5 clk = ~clk;

    logic rd_en, out_valid, busy, done;
    logic [AW-1:0] rd_addr, out_addr;
    logic [DW-1:0] rd_data, out_data;
    logic rd_en0, out_valid0, busy0, done0;
    logic [AW-1:0] rd_addr0, out_addr0;
    logic [DW-1:0] rd_data0, out_data0;
    logic rd_en3, out_valid3, busy3, done3;
    logic [AW-1:0] rd_addr3, out_addr3;
    logic [DW-1:0] rd_data3, out_data3;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DW-1:0] checksum, cs0, cs3;
`endif

    int pat = 0;
    int checks = 0, errors = 0;
    int beats = 0;

    function automatic logic [DW-1:0] data_of(int p, int i);
        return p == 0 ? 32'(i * 3) : (32'hA5A5_0000 | 32'(i));
    endfunction

    // register-file models: data visible only in the capture cycle, junk otherwise
    always @(posedge clk) rd_data <= rd_en ? data_of(pat, int'(rd_addr)) : JUNK;
    assign rd_data0 = rd_en0 ? data_of(0, int'(rd_addr0)) : JUNK;
    logic [DW-1:0] p3 [3];
    logic [2:0] v3 = 3'b000;
    always @(posedge clk) begin
        p3[0] <= data_of(0, int'(rd_addr3));
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        v3 <= {v3[1:0], rd_en3};
    end
    assign rd_data3 = v3[2] ? p3[2] : JUNK;

    reg_dump_reader dut (
        .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done)
`ifdef REG_DUMP_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );
    reg_dump_reader #(.NUM_REGS(4), .READ_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(s_start), .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .out_valid(out_valid0), .out_ready(1'b1), .out_addr(out_addr0), .out_data(out_data0),
        .busy(busy0), .done(done0)
`ifdef REG_DUMP_CHECKSUM_EN
        , .checksum(cs0)
`endif
    );
    reg_dump_reader #(.NUM_REGS(4), .READ_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(s_start), .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3),
        .out_valid(out_valid3), .out_ready(1'b1), .out_addr(out_addr3), .out_data(out_data3),
        .busy(busy3), .done(done3)
`ifdef REG_DUMP_CHECKSUM_EN
        , .checksum(cs3)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;
    beat_t q[$];

    // scoreboard: every handshake on the main DUT pops the next expected word
    always @(negedge clk) begin
        beat_t e;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected beat: got addr %0d, no word expected", out_addr);
            end else begin
                e = q.pop_front();
                chk("beat addr", 64'(out_addr), 64'(e.a));
                chk("beat data", 64'(out_data), 64'(e.d));
            end
            beats++;
        end
    end

    task automatic load_pass(input int p);
        pat = p;
        beats = 0;
        q.delete();
        for (int i = 0; i < 32; i++) q.push_back(beat_t'{AW'(i), data_of(p, i)});
    endtask

    task automatic run_pass(input int p, input int sb, input int sl, input int exp_cyc);
        int n = 1, stalled = 0, got = -1;
        bit busy_ok = 1, stall_ok = 1;
        logic [DW-1:0] xs = '0;
        for (int i = 0; i < 32; i++) xs ^= data_of(p, i);
        load_pass(p);
        start = 1;
        @(posedge clk) #1 start = 0;
`ifdef REG_DUMP_CHECKSUM_EN
        chk("checksum cleared on start", 64'(checksum), 64'(0));
`endif
        while (n < 400) begin
            if (done) begin
                got = n;
                break;
            end
            if (!busy) busy_ok = 0;
            if (beats == sb && out_valid && stalled < sl) begin
                out_ready = 0;
                stalled++;
                if (!(out_addr == AW'(sb) && out_data == data_of(p, sb) && !rd_en)) stall_ok = 0;
            end else
                out_ready = 1;
            @(posedge clk) #1;
            n++;
        end
        out_ready = 1;
        chk("done latency", 64'(got), 64'(exp_cyc));
        chk("busy during pass", 64'(busy_ok), 64'(1));
        chk("beat count", 64'(beats), 64'(32));
        chk("busy low at done", 64'(busy), 64'(0));
        if (sl > 0) begin
            chk("stall cycles", 64'(stalled), 64'(sl));
            chk("stall hold", 64'(stall_ok), 64'(1));
        end
`ifdef REG_DUMP_CHECKSUM_EN
        chk("checksum at done", 64'(checksum), 64'(xs));
        if (p == 1) chk("checksum pattern1", 64'(checksum), 64'(0));
`endif
        @(posedge clk) #1;
        chk("done one cycle", 64'(done), 64'(0));
    endtask

    typedef struct {
        int p;
        int sb;
        int sl;
        int cyc;
    } vec_t;
    vec_t vt [5];

    initial begin
        int n, r0, r3, v0, v3c, d0, d3, c0, c3;
        bit quiet;
        vt[0] = '{0, -1, 0, 97};
        vt[1] = '{0, 5, 10, 107};
        vt[2] = '{1, -1, 0, 97};
        vt[3] = '{0, 0, 3, 100};
        vt[4] = '{1, 31, 1, 98};

        #2 rst = 1;
        #2;
        chk("reset rd_en", 64'(rd_en), 64'(0));
        chk("reset out_valid", 64'(out_valid), 64'(0));
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset rd_addr", 64'(rd_addr), 64'(0));
        chk("reset out_addr", 64'(out_addr), 64'(0));
        chk("reset out_data", 64'(out_data), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(posedge clk) #1;

        foreach (vt[i]) run_pass(vt[i].p, vt[i].sb, vt[i].sl, vt[i].cyc);

        // asynchronous reset while beat 12 is presented
        load_pass(0);
        start = 1;
        @(posedge clk) #1 start = 0;
        n = 0;
        while (!(beats == 12 && out_valid) && n < 200) begin
            @(posedge clk) #1;
            n++;
        end
        chk("reached beat 12", 64'(out_addr), 64'(12));
        #2 rst = 1;
        #1;
        chk("mid rst out_valid", 64'(out_valid), 64'(0));
        chk("mid rst busy", 64'(busy), 64'(0));
        chk("mid rst rd_en", 64'(rd_en), 64'(0));
        chk("mid rst out_addr", 64'(out_addr), 64'(0));
        chk("mid rst out_data", 64'(out_data), 64'(0));
        quiet = 1;
        repeat (3) begin
            @(posedge clk) #1;
            if (done || busy) quiet = 0;
        end
        rst = 0;
        q.delete();
        repeat (3) begin
            @(posedge clk) #1;
            if (done || busy) quiet = 0;
        end
        chk("no done after reset", 64'(quiet), 64'(1));
        run_pass(0, -1, 0, 97);

        // start held high: exactly one pass, next begins after IDLE
        load_pass(0);
        start = 1;
        n = 0;
        while (!done && n < 400) begin
            @(posedge clk) #1;
            n++;
        end
        chk("held start done latency", 64'(n), 64'(97));
        @(posedge clk) #1;
        chk("held start idle busy", 64'(busy), 64'(0));
        chk("held start idle rd_en", 64'(rd_en), 64'(0));
        chk("held start idle done", 64'(done), 64'(0));
        @(posedge clk) #1;
        chk("held start restart busy", 64'(busy), 64'(1));
        chk("held start restart rd_en", 64'(rd_en), 64'(1));
        chk("held start restart addr", 64'(rd_addr), 64'(0));
        start = 0;
        #2 rst = 1;
        @(posedge clk) #1 rst = 0;
        q.delete();
        @(posedge clk) #1;

        // READ_LAT=0 and READ_LAT=3 variants, NUM_REGS=4, ready tied high
        s_start = 1;
        @(posedge clk) #1 s_start = 0;
        n = 1;
        r0 = -1; r3 = -1; v0 = -1; v3c = -1; d0 = -1; d3 = -1; c0 = 0; c3 = 0;
        while ((d0 < 0 || d3 < 0) && n < 60) begin
            if (rd_en0 && r0 < 0) r0 = n;
            if (rd_en3 && r3 < 0) r3 = n;
            if (out_valid0) begin
                if (v0 < 0) v0 = n;
                chk("lat0 addr", 64'(out_addr0), 64'(c0));
                chk("lat0 data", 64'(out_data0), 64'(data_of(0, c0)));
                c0++;
            end
            if (out_valid3) begin
                if (v3c < 0) v3c = n;
                chk("lat3 addr", 64'(out_addr3), 64'(c3));
                chk("lat3 data", 64'(out_data3), 64'(data_of(0, c3)));
                c3++;
            end
            if (done0 && d0 < 0) d0 = n;
            if (done3 && d3 < 0) d3 = n;
            @(posedge clk) #1;
            n++;
        end
        chk("lat0 rd_en to valid", 64'(v0 - r0), 64'(1));
        chk("lat3 rd_en to valid", 64'(v3c - r3), 64'(4));
        chk("lat0 done latency", 64'(d0), 64'(9));
        chk("lat3 done latency", 64'(d3), 64'(21));
        chk("lat0 beats", 64'(c0), 64'(4));
        chk("lat3 beats", 64'(c3), 64'(4));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
